// File: rtl/sevenseg_scan_driver_if.sv
// Display-side bundle between the stopwatch core (master) and the seven-segment scan driver (slave).
// Carries digit values, per-digit masks and the multiplexed display pins.
interface sevenseg_scan_driver_if;
   logic [15:0] digits;
   logic [3:0]  dp_mask;
   logic [3:0]  blink_mask;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;

   modport master (
      output digits, dp_mask, blink_mask,
      input  seg, dp, an
   );

   modport slave (
      input  digits, dp_mask, blink_mask,
      output seg, dp, an
   );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed common-anode 4-digit seven-segment driver with per-slot ghosting blank,
// frame-synchronous value latching and per-digit blinking.
module sevenseg_scan_driver #(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 500,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input logic                   clk,
   input logic                   rst,
   sevenseg_scan_driver_if.slave disp_if
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_CYCLES);
   localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             blink_phase_q, blink_phase_d;
   logic [15:0]      frame_buf_q, frame_buf_d;
   logic [3:0]       dpm_buf_q, dpm_buf_d;
   logic [3:0]       blm_buf_q, blm_buf_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic             slot_end;
   logic             frame_end;
   logic             visible;
   logic [3:0]       nibble;

   // Active-low gfedcba patterns, hex digits included for adjust/debug display.
   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Next-state for scan position, frame latching and blink phase, plus registered pin values.
   always_comb begin
      scan_cnt_d    = scan_cnt_q;
      idx_d         = idx_q;
      frame_cnt_d   = frame_cnt_q;
      blink_phase_d = blink_phase_q;
      frame_buf_d   = frame_buf_q;
      dpm_buf_d     = dpm_buf_q;
      blm_buf_d     = blm_buf_q;
      an_d          = 4'b1111;
      seg_d         = 7'b1111111;
      dp_d          = 1'b1;

      slot_end  = (scan_cnt_q == SCAN_LAST);
      frame_end = slot_end && (idx_q == 2'd3);
      nibble    = frame_buf_q[{idx_q, 2'b00} +: 4];
      visible   = (scan_cnt_q >= BLANK_END) && !(blm_buf_q[idx_q] && blink_phase_q);

      if (slot_end) begin
         scan_cnt_d = '0;
         idx_d      = idx_q + 2'd1;
      end else begin
         scan_cnt_d = scan_cnt_q + CNT_W'(1);
      end

      // Values are only taken at frame end so a frame never mixes old and new digits.
      if (frame_end) begin
         frame_buf_d = disp_if.digits;
         dpm_buf_d   = disp_if.dp_mask;
         blm_buf_d   = disp_if.blink_mask;
         if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + FRM_W'(1);
         end
      end

      if (visible) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = decode(nibble);
         dp_d  = ~dpm_buf_q[idx_q];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_q    <= '0;
         idx_q         <= 2'd0;
         frame_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         frame_buf_q   <= disp_if.digits;
         dpm_buf_q     <= disp_if.dp_mask;
         blm_buf_q     <= disp_if.blink_mask;
         an_q          <= 4'b1111;
         seg_q         <= 7'b1111111;
         dp_q          <= 1'b1;
      end else begin
         scan_cnt_q    <= scan_cnt_d;
         idx_q         <= idx_d;
         frame_cnt_q   <= frame_cnt_d;
         blink_phase_q <= blink_phase_d;
         frame_buf_q   <= frame_buf_d;
         dpm_buf_q     <= dpm_buf_d;
         blm_buf_q     <= blm_buf_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
      end
   end

   assign disp_if.an  = an_q;
   assign disp_if.seg = seg_q;
   assign disp_if.dp  = dp_q;

endmodule
